booth4_mul_unit: RTL
====================

# booth4_mul_unit

Parametrised radix-4 Booth sequential multiplier for the M-extension datapath. It is the next generation of the team's `Booth4` multiplier. It adds a ready/start/valid handshake and the four RV32M multiply modes (MUL, MULH, MULHSU, MULHU). It covers the full operand range, including the most-negative value, which the previous generation could not. The execute stage issues one operation at a time and consumes the one-cycle `valid` pulse.

## Interface
- `N`, default 32: operand width. Must be even and ≥ 4; elaboration fails otherwise.
- `clk`  input  1: single clock, all state updates on the rising edge.
- `rst`  input  1: reset, synchronous, active-low.
- `start`  input  1: request. Accepted only on an edge where `start`=1 and `ready`=1.
- `mode`  input  2: 00 MUL (low half, signed×signed), 01 MULH (high, s×s), 10 MULHSU (high, signed `op_a` × unsigned `op_b`), 11 MULHU (high, u×u).
- `op_a`  input  N: multiplicand, latched on accept.
- `op_b`  input  N: multiplier, latched on accept.
- `ready`  output  1: unit idle, will accept `start`.
- `valid`  output  1: one-cycle pulse, `result`/`product` valid.
- `result`  output  N: mode-selected half of the product.
- `product`  output  2N: full 2N-bit product under the signedness of `mode`.

## Operation
- **States:** IDLE, CALC, DONE.
  - IDLE → CALC on accept.
  - CALC → DONE when the iteration count reaches K = (N+2)/2.
  - DONE → IDLE unconditionally.
- **Accept (IDLE, `start`=1):**
  - Latch `op_a`, `op_b` and `mode`.
  - Extend both operands to N+2 bits. Sign-extend when that operand is signed for the mode, zero-extend otherwise. `op_a` is signed for modes 00/01/10; `op_b` is signed for modes 00/01.
  - Clear the accumulator and set Q₋₁ = 0.
- **CALC:** one radix-4 step per cycle.
  - Examine the triplet {Q[1], Q[0], Q₋₁}.
  - Add 0, ±M or ±2M to an accumulator of width N+4. M is the extended multiplicand.
  - Arithmetic-shift {acc, Q, Q₋₁} right by 2.
  - Increment the iteration counter.
- **DONE:**
  - `product` = low 2N bits of the final {acc, Q}.
  - `result` = `product`[N-1:0] for mode 00, `product`[2N-1:N] otherwise.
  - `valid`=1.
- `result` and `product` hold their value until the next DONE or reset.
- `start` while `ready`=0 is ignored; no queueing.
- Input changes after accept have no effect on the operation in flight.
- Operands are never pre-negated. The −2^(N-1) × −2^(N-1) case needs no special casing because of the 2-bit extension.

## Timing
- **Reset** (`rst`=0 at an edge):
  - State goes to IDLE, counter to 0.
  - `ready`=1, `valid`=0, `result`=0, `product`=0.
  - Reset during CALC or DONE aborts the operation; no `valid` is emitted for it.
- **Latency:** accept at edge E0.
  - CALC occupies the K cycles after E0.
  - `valid`=1 in cycle K+1 after E0. For N=32 that is cycle 18; for N=8 it is cycle 6.
- **`ready`:**
  - 1 only in IDLE; drops in the cycle after the accepting edge.
  - Returns to 1 in the cycle after `valid`.
  - Initiation interval is K+2 cycles.
- **Back-to-back:** `start` held high continuously gives one accept per K+2 cycles, with no lost or duplicated operations.
- `valid` is never high for two consecutive cycles.

## Test plan
- **Exhaustive sweep:** N=8, all 65 536 operand pairs × 4 modes, start pulsed when `ready`. Each `product` must equal the reference product for that mode's signedness, and `result` must be the selected half. Zero mismatches.
- **Corner values:** N=8.
  - `op_a`=`op_b`=0x80, mode 00 → `product`=0x4000, `result`=0x00.
  - Same operands, mode 11 → `product`=0x4000, `result`=0x40.
  - `op_a`=`op_b`=0xFF: mode 11 → `product`=0xFE01, `result`=0xFE. Mode 10 → `product`=0xFF01, `result`=0xFF. Mode 01 → `product`=0x0001, `result`=0x00.
- **Latency and handshake:** N=32, accept 7×−3 mode 00.
  - `ready` low from the next cycle.
  - `valid` high exactly in cycle 18, `result`=0xFFFFFFEB.
  - `ready` high in cycle 19.
- **Busy-time stimulus is ignored:** accept 5×6 mode 00, then pulse `start` with 9×9 and toggle `op_a`/`op_b` during CALC. Required: a single `valid` with `result`=30, and no second `valid` until a new accept.
- **Reset mid-operation:**
  - Assert `rst`=0 for one cycle at CALC iteration 3.
  - Following cycle: `ready`=1, `valid`=0, `result`=0, `product`=0, and no `valid` ever appears for the aborted operation.
  - A subsequent 2×3 operation completes with `result`=6 at nominal latency.
- **Back-to-back:** hold `start`=1 with a new operand pair presented each accept (3×4, −2×5, 0x7FFFFFFF×2 MULHU), N=32. Required `result` values are 12, 0xFFFFFFF6 and 0x00000000, with accepts exactly K+2=19 cycles apart.

Source files
------------

// File: rtl/booth4_mul_unit.sv
// Radix-4 Booth sequential multiplier with ready/start/valid handshake and the
// four RV32M multiply modes. One Booth digit is retired per CALC cycle.
module booth4_mul_unit #(
    parameter int unsigned N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [N-1:0]   op_a,
    input  logic [N-1:0]   op_b,
    output logic           ready,
    output logic           valid,
    output logic [N-1:0]   result,
    output logic [2*N-1:0] product
);

    // Two extra operand bits let unsigned and most-negative operands use the
    // same signed Booth recoding with no special cases.
    localparam int unsigned K  = (N + 2) / 2;
    localparam int unsigned CW = $clog2(K + 1);
    localparam int unsigned AW = N + 4;
    localparam int unsigned QW = N + 2;

    if ((N % 2) != 0 || N < 4) begin : g_bad_n
        $error("booth4_mul_unit: N must be even and >= 4");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    m_q, m_d;
    logic [QW-1:0]    q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [1:0]       mode_q, mode_d;
    logic [N-1:0]     result_q, result_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [AW-1:0]    addend;
    logic [AW-1:0]    sum;
    logic             a_signed;
    logic             b_signed;

    // Next-state logic: accept, Booth step with 2-bit arithmetic shift, result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        mode_d    = mode_q;
        result_d  = result_q;
        product_d = product_q;

        a_signed = (mode != 2'b11);
        b_signed = ~mode[1];

        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m_q;
            3'b011:         addend = m_q << 1;
            3'b100:         addend = -(m_q << 1);
            3'b101, 3'b110: addend = -m_q;
            default:        addend = '0;
        endcase
        sum = acc_q + addend;

        case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = {{4{a_signed & op_a[N-1]}}, op_a};
                    q_d     = {{2{b_signed & op_b[N-1]}}, op_b};
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    mode_d  = mode;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
                q_d   = {sum[1:0], q_q[QW-1:2]};
                qm1_d = q_q[1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CW'(K)) begin
                    state_d   = StDone;
                    // Low 2N bits of the final {acc, Q}.
                    product_d = {acc_d[N-3:0], q_d};
                    result_d  = (mode_q == 2'b00) ? product_d[N-1:0] : product_d[2*N-1:N];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            mode_q    <= 2'b00;
            result_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            mode_q    <= mode_d;
            result_q  <= result_d;
            product_q <= product_d;
        end
    end

    // Handshake and data outputs decoded from registered state.
    always_comb begin
        ready   = (state_q == StIdle);
        valid   = (state_q == StDone);
        result  = result_q;
        product = product_q;
    end

endmodule
